// File: rtl/cache_stage_pkg.sv
// Shared types and constants for the memory stage: cache geometry, store-buffer
// entry layout, instruction-type encodings and byte-lane helpers.
package cache_stage_pkg;
  localparam int WORD_SIZE            = 32;
  localparam int INSTR_TYPE_SZ        = 2;
  localparam int CACHE_LINE_SIZE      = 128;
  localparam int ROB_ENTRY_WIDTH      = 4;
  localparam int STORE_BUFFER_ENTRIES = 4;
  localparam int SB_PTR_W             = $clog2(STORE_BUFFER_ENTRIES);
  localparam int NUM_LINES            = 4;
  localparam int OFF_W                = 4;
  localparam int IDX_W                = 2;
  localparam int TAG_W                = WORD_SIZE - OFF_W - IDX_W;

  localparam logic [INSTR_TYPE_SZ-1:0] INSTR_TYPE_ALU   = 2'd0;
  localparam logic [INSTR_TYPE_SZ-1:0] INSTR_TYPE_LOAD  = 2'd1;
  localparam logic [INSTR_TYPE_SZ-1:0] INSTR_TYPE_STORE = 2'd2;

  typedef enum logic {S_IDLE, S_WAIT} fill_state_t;

  typedef struct packed {
    logic [WORD_SIZE-1:0]       addr;
    logic [WORD_SIZE-1:0]       data;
    logic [2:0]                 funct3;
    logic [ROB_ENTRY_WIDTH-1:0] rob_id;
    logic                       committed;
  } sb_entry_t;

  function automatic logic [WORD_SIZE-1:0] load_extend(
    input logic [CACHE_LINE_SIZE-1:0] line, input logic [OFF_W-1:0] off, input logic [2:0] f3);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = line[{off[3:2], 5'b0} +: 32];
    b = w[{off[1:0], 3'b0} +: 8];
    h = w[{off[1], 4'b0} +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  // Replicate store data across the line and splice in only the enabled bytes.
  function automatic logic [CACHE_LINE_SIZE-1:0] store_merge(
    input logic [CACHE_LINE_SIZE-1:0] line, input logic [OFF_W-1:0] off,
    input logic [2:0] f3, input logic [WORD_SIZE-1:0] data);
    logic [15:0]                be;
    logic [CACHE_LINE_SIZE-1:0] rep, mask;
    case (f3[1:0])
      2'b00:   begin be = 16'h0001 << off; rep = {16{data[7:0]}};  end
      2'b01:   begin be = 16'h0003 << off; rep = {8{data[15:0]}};  end
      default: begin be = 16'h000F << {off[3:2], 2'b00}; rep = {4{data}}; end
    endcase
    for (int i = 0; i < 16; i++) mask[i*8 +: 8] = {8{be[i]}};
    return (line & ~mask) | (rep & mask);
  endfunction
endpackage

// File: rtl/cache_stage_sb.sv
// Store buffer: circular FIFO of pending stores, committed by ROB tag and
// drained in order from the head; flags any live entry on a given word address.
module store_buffer
  import cache_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  sb_entry_t                  push_entry,
  input  logic                       pop,
  input  logic                       commit,
  input  logic [ROB_ENTRY_WIDTH-1:0] commit_rob_id,
  input  logic [WORD_SIZE-3:0]       match_waddr,
  output logic [WORD_SIZE-1:0]       head_addr,
  output logic [WORD_SIZE-1:0]       head_data,
  output logic [2:0]                 head_funct3,
  output logic                       head_committed,
  output logic                       head_valid,
  output logic                       full,
  output logic                       match
);
  sb_entry_t [STORE_BUFFER_ENTRIES-1:0] mem_q;
  logic [SB_PTR_W-1:0]                  head_ptr, tail_ptr;
  logic [SB_PTR_W:0]                    entries;
  logic [STORE_BUFFER_ENTRIES-1:0]      live, hit_v;

  for (genvar i = 0; i < STORE_BUFFER_ENTRIES; i++) begin : g_ent
    logic [SB_PTR_W-1:0] rel;
    assign rel      = SB_PTR_W'(i) - head_ptr;
    assign live[i]  = {1'b0, rel} < entries;
    assign hit_v[i] = live[i] && (mem_q[i].addr[WORD_SIZE-1:2] == match_waddr);
  end

  assign match          = |hit_v;
  assign full           = entries == (SB_PTR_W+1)'(STORE_BUFFER_ENTRIES);
  assign head_valid     = entries != '0;
  assign head_addr      = mem_q[head_ptr].addr;
  assign head_data      = mem_q[head_ptr].data;
  assign head_funct3    = mem_q[head_ptr].funct3;
  assign head_committed = mem_q[head_ptr].committed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      entries  <= '0;
    end else begin
      for (int i = 0; i < STORE_BUFFER_ENTRIES; i++)
        if (commit && live[i] && mem_q[i].rob_id == commit_rob_id) mem_q[i].committed <= 1'b1;
      if (push) begin
        mem_q[tail_ptr] <= push_entry;
        tail_ptr        <= tail_ptr + 1'b1;
      end
      if (pop) head_ptr <= head_ptr + 1'b1;
      case ({push, pop})
        2'b10:   entries <= entries + 1'b1;
        2'b01:   entries <= entries - 1'b1;
        default: entries <= entries;
      endcase
    end
  end
endmodule

// File: rtl/cache_stage.sv
// Memory stage: 4-line direct-mapped write-back cache with a single outstanding
// line fill, fronted by a store buffer that drains committed stores into the cache.
module cache_stage
  import cache_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INSTR_TYPE_SZ-1:0]   instruction_type,
  output logic [INSTR_TYPE_SZ-1:0]   instruction_type_out,
  input  logic [WORD_SIZE-1:0]       pc,
  output logic [WORD_SIZE-1:0]       pc_out,
  input  logic [2:0]                 funct3,
  input  logic [WORD_SIZE-1:0]       v_mem_addr,
  input  logic [WORD_SIZE-1:0]       s2,
  input  logic [ROB_ENTRY_WIDTH-1:0] rob_id,
  output logic [ROB_ENTRY_WIDTH-1:0] rob_id_out,
  input  logic                       valid,
  output logic                       valid_out,
  output logic                       stall_out,
  output logic [WORD_SIZE-1:0]       read_data,
  output logic                       mem_req,
  output logic [WORD_SIZE-1:0]       mem_req_addr,
  output logic                       mem_write,
  output logic [WORD_SIZE-1:0]       mem_write_addr,
  output logic [CACHE_LINE_SIZE-1:0] mem_write_data,
  input  logic                       mem_res,
  input  logic [WORD_SIZE-1:0]       mem_res_addr,
  input  logic [CACHE_LINE_SIZE-1:0] mem_res_data,
  input  logic                       rob_store_permission,
  input  logic [ROB_ENTRY_WIDTH-1:0] rob_sb_permission_rob_id
);
  fill_state_t                               state_q, state_d;
  logic [NUM_LINES-1:0]                      line_vld, line_dirty;
  logic [NUM_LINES-1:0][TAG_W-1:0]           line_tag;
  logic [NUM_LINES-1:0][CACHE_LINE_SIZE-1:0] line_data;
  logic [WORD_SIZE-1:0]                      pend_addr;

  logic [WORD_SIZE-1:0] sb_head_addr, sb_head_data;
  logic [2:0]           sb_head_funct3;
  logic                 sb_head_committed, sb_head_valid, sb_full, sb_match;

  logic [IDX_W-1:0] ld_idx, dr_idx, fill_idx;
  logic is_load, is_store, is_other, ld_hit, dr_hit, ld_miss;
  logic drain_rdy, drain_wr, drain_miss, fill, accept, push;

  assign ld_idx   = v_mem_addr[OFF_W +: IDX_W];
  assign dr_idx   = sb_head_addr[OFF_W +: IDX_W];
  assign fill_idx = pend_addr[OFF_W +: IDX_W];
  assign is_load  = valid && instruction_type == INSTR_TYPE_LOAD;
  assign is_store = valid && instruction_type == INSTR_TYPE_STORE;
  assign is_other = valid && !is_load && !is_store;
  assign ld_hit   = line_vld[ld_idx] && line_tag[ld_idx] == v_mem_addr[WORD_SIZE-1 -: TAG_W];
  assign dr_hit   = line_vld[dr_idx] && line_tag[dr_idx] == sb_head_addr[WORD_SIZE-1 -: TAG_W];
  // Loads to a word still sitting in the SB wait for it to drain; no forwarding.
  assign ld_miss    = is_load && !sb_match && !ld_hit;
  assign drain_rdy  = sb_head_valid && sb_head_committed && state_q == S_IDLE;
  assign drain_wr   = drain_rdy && dr_hit;
  assign drain_miss = drain_rdy && !dr_hit;
  assign fill       = state_q == S_WAIT && mem_res && mem_res_addr == pend_addr;
  assign push       = is_store && !sb_full;
  assign accept     = (is_load && !sb_match && ld_hit) || push || is_other;

  store_buffer sb (
    .clk, .rst, .push,
    .push_entry     ('{addr: v_mem_addr, data: s2, funct3: funct3, rob_id: rob_id, committed: 1'b0}),
    .pop            (drain_wr),
    .commit         (rob_store_permission),
    .commit_rob_id  (rob_sb_permission_rob_id),
    .match_waddr    (v_mem_addr[WORD_SIZE-1:2]),
    .head_addr      (sb_head_addr),
    .head_data      (sb_head_data),
    .head_funct3    (sb_head_funct3),
    .head_committed (sb_head_committed),
    .head_valid     (sb_head_valid),
    .full           (sb_full),
    .match          (sb_match)
  );

  always_comb begin
    state_d        = state_q;
    stall_out      = 1'b0;
    mem_req        = 1'b0;
    mem_req_addr   = '0;
    mem_write      = 1'b0;
    mem_write_addr = '0;
    mem_write_data = '0;
    if (!rst) begin
      stall_out = valid && !accept;
      case (state_q)
        S_IDLE: begin
          // Pipeline load miss takes the single request slot ahead of a drain miss.
          if (ld_miss) begin
            mem_req      = 1'b1;
            mem_req_addr = {v_mem_addr[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
            state_d      = S_WAIT;
          end else if (drain_miss) begin
            mem_req      = 1'b1;
            mem_req_addr = {sb_head_addr[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
            state_d      = S_WAIT;
          end
        end
        S_WAIT: begin
          if (fill) begin
            state_d = S_IDLE;
            if (line_vld[fill_idx] && line_dirty[fill_idx]) begin
              mem_write      = 1'b1;
              mem_write_addr = {line_tag[fill_idx], fill_idx, {OFF_W{1'b0}}};
              mem_write_data = line_data[fill_idx];
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q              <= S_IDLE;
      pend_addr            <= '0;
      line_vld             <= '0;
      line_dirty           <= '0;
      valid_out            <= 1'b0;
      rob_id_out           <= '0;
      pc_out               <= '0;
      instruction_type_out <= '0;
      read_data            <= '0;
    end else begin
      state_q   <= state_d;
      valid_out <= accept;
      if (mem_req) pend_addr <= mem_req_addr;
      if (fill) begin
        line_vld[fill_idx]   <= 1'b1;
        line_dirty[fill_idx] <= 1'b0;
      end
      if (drain_wr) line_dirty[dr_idx] <= 1'b1;
      if (accept) begin
        rob_id_out           <= rob_id;
        pc_out               <= pc;
        instruction_type_out <= instruction_type;
        read_data            <= is_load ? load_extend(line_data[ld_idx], v_mem_addr[OFF_W-1:0], funct3) : '0;
      end
    end
  end

  // Tag/data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill) begin
      line_tag[fill_idx]  <= pend_addr[WORD_SIZE-1 -: TAG_W];
      line_data[fill_idx] <= mem_res_data;
    end else if (drain_wr) begin
      line_data[dr_idx] <= store_merge(line_data[dr_idx], sb_head_addr[OFF_W-1:0], sb_head_funct3, sb_head_data);
    end
  end
endmodule

// File: tb/tb_cache_stage.sv
// Directed bench for cache_stage: scoreboard of expected completions checked by a
// monitor, plus a line-memory responder that serves fills and captures writebacks.
module tb_cache_stage;
  import cache_stage_pkg::*;

  logic                       clk = 1'b0, rst = 1'b1;
  logic [INSTR_TYPE_SZ-1:0]   instruction_type = '0, instruction_type_out;
  logic [WORD_SIZE-1:0]       pc = '0, pc_out, v_mem_addr = '0, s2 = '0, read_data;
  logic [2:0]                 funct3 = '0;
  logic [ROB_ENTRY_WIDTH-1:0] rob_id = '0, rob_id_out, rob_sb_permission_rob_id = '0;
  logic                       valid = 1'b0, valid_out, stall_out, mem_req, mem_write;
  logic [WORD_SIZE-1:0]       mem_req_addr, mem_write_addr, mem_res_addr = '0;
  logic [CACHE_LINE_SIZE-1:0] mem_write_data, mem_res_data = '0;
  logic                       mem_res = 1'b0, rob_store_permission = 1'b0;

  always #5 clk = ~clk;

  cache_stage dut (
    .clk(clk), .rst(rst), .instruction_type(instruction_type),
    .instruction_type_out(instruction_type_out), .pc(pc), .pc_out(pc_out),
    .funct3(funct3), .v_mem_addr(v_mem_addr), .s2(s2), .rob_id(rob_id),
    .rob_id_out(rob_id_out), .valid(valid), .valid_out(valid_out),
    .stall_out(stall_out), .read_data(read_data), .mem_req(mem_req),
    .mem_req_addr(mem_req_addr), .mem_write(mem_write), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_res(mem_res), .mem_res_addr(mem_res_addr),
    .mem_res_data(mem_res_data), .rob_store_permission(rob_store_permission),
    .rob_sb_permission_rob_id(rob_sb_permission_rob_id)
  );

  typedef struct {
    logic [ROB_ENTRY_WIDTH-1:0] rob;
    logic [WORD_SIZE-1:0]       pc;
    logic [INSTR_TYPE_SZ-1:0]   it;
    logic [WORD_SIZE-1:0]       rd;
  } exp_t;

  exp_t                 exp_q[$];
  int                   n_vec = 0, n_err = 0;
  logic [127:0]         mem_model [logic [31:0]];
  int                   wb_cnt = 0, rsp_cnt = 0;
  logic [31:0]          wb_addr = '0, rsp_addr = '0;
  logic [127:0]         wb_data = '0;
  logic                 rsp_busy = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a + 32'd12, a + 32'd8, a + 32'd4, a};
  endfunction

  // Monitor: every completion pops the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid_out) begin
      if (exp_q.size() == 0) check("unexpected_valid_out", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("resp_rob", rob_id_out, e.rob);
        check("resp_pc", pc_out, e.pc);
        check("resp_type", instruction_type_out, e.it);
        check("resp_data", read_data, e.rd);
      end
    end
  end

  // Responder: fill arrives three cycles after the request; writebacks update the model.
  initial forever begin
    @(negedge clk);
    mem_res = 1'b0;
    if (rsp_busy && rsp_cnt == 0) begin
      mem_res      = 1'b1;
      mem_res_addr = rsp_addr;
      mem_res_data = line_of(rsp_addr);
      rsp_busy     = 1'b0;
    end
    #2;
    if (mem_write) begin
      mem_model[mem_write_addr] = mem_write_data;
      wb_cnt++;
      wb_addr = mem_write_addr;
      wb_data = mem_write_data;
    end
    if (rsp_busy) rsp_cnt--;
    else if (mem_req && !mem_res) begin
      rsp_busy = 1'b1;
      rsp_addr = mem_req_addr;
      rsp_cnt  = 2;
    end
  end

  task automatic drive(input logic [1:0] it, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] rob);
    instruction_type = it; funct3 = f3; v_mem_addr = a; s2 = d; rob_id = rob;
    pc = 32'h100 + 32'(rob) * 4; valid = 1'b1;
  endtask

  // Called at a negedge with inputs held; records the expectation on acceptance.
  task automatic wait_accept(input logic [31:0] rd, input string name);
    exp_t e;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (!stall_out) begin
        e.rob = rob_id; e.pc = pc; e.it = instruction_type; e.rd = rd;
        exp_q.push_back(e);
        @(posedge clk); #1;
        valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check({name, "_timeout"}, 1, 0);
    valid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] it, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] rob, input logic [31:0] rd,
                       input string name);
    @(negedge clk);
    drive(it, f3, a, d, rob);
    wait_accept(rd, name);
  endtask

  initial begin
    mem_model[32'd1024] = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
    repeat (3) @(negedge clk);
    check("rst_valid_out", valid_out, 0);
    check("rst_ctl", {stall_out, mem_req, mem_write}, 3'b000);
    check("rst_read_data", read_data, 0);
    check("rst_entries", dut.sb.entries, 0);
    rst = 1'b0;

    // Fill the SB with uncommitted stores to line 2064 (index 1).
    for (int k = 0; k < 4; k++)
      issue(INSTR_TYPE_STORE, 3'b010, 32'd2064 + 32'(k) * 4, 32'hA0 + 32'(k), 4'(8 + k), 0, "sb_fill");
    check("sb_full_entries", dut.sb.entries, 4);

    @(negedge clk);
    drive(INSTR_TYPE_STORE, 3'b010, 32'd1024, 32'hCAFE, 4'd1);
    for (int i = 0; i < 10; i++) begin
      #1 check("full_store_stall", {stall_out, mem_req}, 2'b10);
      @(negedge clk);
    end
    drive(INSTR_TYPE_LOAD, 3'b010, 32'd1024, 0, 4'd5);
    #1 check("miss_req", {mem_req, stall_out, mem_req_addr}, {1'b1, 1'b1, 32'd1024});
    @(negedge clk);
    #1 check("miss_req_pulse", {mem_req, stall_out}, 2'b01);
    @(negedge clk);
    wait_accept(32'hDEADBEEF, "lw_fill");

    issue(INSTR_TYPE_LOAD, 3'b000, 32'd1027, 0, 4'd1, 32'hFFFFFFDE, "lb");
    issue(INSTR_TYPE_LOAD, 3'b100, 32'd1027, 0, 4'd2, 32'h000000DE, "lbu");
    issue(INSTR_TYPE_LOAD, 3'b001, 32'd1026, 0, 4'd4, 32'hFFFFDEAD, "lh");
    issue(INSTR_TYPE_LOAD, 3'b101, 32'd1024, 0, 4'd0, 32'h0000BEEF, "lhu");
    issue(INSTR_TYPE_LOAD, 3'b010, 32'd1028, 0, 4'd15, 32'h11111111, "lw_w1");
    issue(INSTR_TYPE_ALU, 3'b000, 32'd0, 32'h77, 4'd2, 0, "alu");

    // Commit the four parked stores and let them drain (one drain miss, then hits).
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rob_store_permission = 1'b1;
      rob_sb_permission_rob_id = 4'(8 + k);
    end
    @(negedge clk);
    rob_store_permission = 1'b0;
    for (int k = 0; k < 100 && dut.sb.entries != 0; k++) @(negedge clk);
    check("sb_drained", dut.sb.entries, 0);

    issue(INSTR_TYPE_STORE, 3'b010, 32'd1024, 32'h12345678, 4'd3, 0, "sw");
    check("sb_one_entry", dut.sb.entries, 1);
    @(negedge clk);
    drive(INSTR_TYPE_LOAD, 3'b010, 32'd1024, 0, 4'd6);
    for (int i = 0; i < 3; i++) begin
      #1 check("ld_sb_stall", {stall_out, mem_req}, 2'b10);
      @(negedge clk);
    end
    rob_store_permission = 1'b1;
    rob_sb_permission_rob_id = 4'd3;
    @(negedge clk);
    rob_store_permission = 1'b0;
    wait_accept(32'h12345678, "lw_after_drain");
    check("sb_empty_after_drain", dut.sb.entries, 0);

    // Same-index load evicts the dirty 1024 line.
    issue(INSTR_TYPE_LOAD, 3'b010, 32'd1088, 0, 4'd12, 32'h00000440, "lw_evict");
    check("wb_count", wb_cnt, 1);
    check("wb_addr", wb_addr, 32'd1024);
    check("wb_word0", wb_data[31:0], 32'h12345678);

    // Reset in the middle of an outstanding fill.
    issue(INSTR_TYPE_STORE, 3'b010, 32'd4000, 32'h55, 4'd7, 0, "sw_park");
    @(negedge clk);
    drive(INSTR_TYPE_LOAD, 3'b010, 32'd3072, 0, 4'd13);
    #1 check("rst_test_req", {mem_req, mem_req_addr}, {1'b1, 32'd3072});
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("wait_rst_ctl", {valid_out, stall_out, mem_req, mem_write}, 4'b0000);
    check("wait_rst_regs", {rob_id_out, pc_out, read_data, instruction_type_out}, 0);
    check("wait_rst_entries", dut.sb.entries, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    valid = 1'b0;
    for (int k = 0; k < 50 && rsp_busy; k++) @(negedge clk);
    check("responder_idle", rsp_busy, 0);
    @(negedge clk);

    // Cache was invalidated; the refetch sees the written-back data.
    issue(INSTR_TYPE_LOAD, 3'b010, 32'd1024, 0, 4'd14, 32'h12345678, "lw_after_rst");
    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule
